// File: rtl/regfile_pkg.sv
// Shared types and constants for the regfile_v2 register file.
package regfile_pkg;

    typedef enum logic {
        CLR_IDLE,
        CLR_RUN
    } clr_state_e;

    localparam int unsigned ERR_W        = 8;
    localparam int unsigned ERR_X0_WR    = 0;
    localparam int unsigned ERR_WR_BUSY  = 1;
    localparam int unsigned ERR_WR_OOR   = 2;
    localparam int unsigned ERR_RD_OOR   = 3;
    localparam int unsigned ERR_CLR_BUSY = 4;

endpackage

// File: rtl/regfile_v2_if.sv
// Bus interface of regfile_v2: write port, two read ports, clear control and error status.
interface regfile_v2_if
    import regfile_pkg::*;
#(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned NUM_REGS = 32
) ();

    localparam int unsigned ADDR_W = $clog2(NUM_REGS);

    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [XLEN-1:0]   wr_data;
    logic [ADDR_W-1:0] rd_addr_a;
    logic [XLEN-1:0]   rd_data_a;
    logic [ADDR_W-1:0] rd_addr_b;
    logic [XLEN-1:0]   rd_data_b;
    logic              clr_req;
    logic              clr_busy;
    logic              err_clr;
    logic [ERR_W-1:0]  error_vector;

    modport master (
        output wr_en, wr_addr, wr_data,
        output rd_addr_a, rd_addr_b,
        output clr_req, err_clr,
        input  rd_data_a, rd_data_b, clr_busy, error_vector
    );

    modport slave (
        input  wr_en, wr_addr, wr_data,
        input  rd_addr_a, rd_addr_b,
        input  clr_req, err_clr,
        output rd_data_a, rd_data_b, clr_busy, error_vector
    );

endinterface

// File: rtl/regfile_read_port.sv
// One combinational read mux of regfile_v2 with range, hardwired-zero and
// optional write forwarding (REGFILE_BYPASS_EN).
module regfile_read_port #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned ZERO_REG = 1
) (
    input  logic [NUM_REGS-1:0][XLEN-1:0] regs_i,
    input  logic [$clog2(NUM_REGS)-1:0]   addr_i,
`ifdef REGFILE_BYPASS_EN
    input  logic                          byp_en_i,
    input  logic [$clog2(NUM_REGS)-1:0]   byp_addr_i,
    input  logic [XLEN-1:0]               byp_data_i,
`endif
    output logic [XLEN-1:0]               data_o,
    output logic                          oor_o
);

    localparam int unsigned ADDR_W  = $clog2(NUM_REGS);
    localparam bit          HAS_OOR = NUM_REGS < (1 << ADDR_W);
    localparam bit          ZR      = ZERO_REG != 0;

    logic in_range;
    logic is_zero;

    generate
        if (HAS_OOR) begin : g_range
            assign in_range = {1'b0, addr_i} < (ADDR_W+1)'(NUM_REGS);
        end else begin : g_full
            assign in_range = 1'b1;
        end
    endgenerate

    assign is_zero = ZR && (addr_i == '0);
    assign oor_o   = !in_range;

    // Range and x0 checks outrank forwarding so illegal reads always return 0.
    always_comb begin
        data_o = '0;
        if (in_range && !is_zero) begin
            data_o = regs_i[addr_i];
`ifdef REGFILE_BYPASS_EN
            if (byp_en_i && (byp_addr_i == addr_i)) begin
                data_o = byp_data_i;
            end
`endif
        end
    end

endmodule

// File: rtl/regfile_v2.sv
// Parametrised integer register file: one write port, two read ports, sequenced
// clear engine and sticky error vector. Optional forwarding under REGFILE_BYPASS_EN.
module regfile_v2
    import regfile_pkg::*;
#(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned ZERO_REG = 1
) (
    input  logic         clk,
    input  logic         rst,
    regfile_v2_if.slave  bus
);

    localparam int unsigned       ADDR_W   = $clog2(NUM_REGS);
    localparam bit                HAS_OOR  = NUM_REGS < (1 << ADDR_W);
    localparam bit                ZR       = ZERO_REG != 0;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

    logic [NUM_REGS-1:0][XLEN-1:0] mem_q;
    clr_state_e                    state_q;
    logic [ADDR_W-1:0]             idx_q;
    logic                          busy_q;
    logic [ERR_W-1:0]              err_q;
    logic [ERR_W-1:0]              err_d;
    logic [ERR_W-1:0]              err_evt;

    logic wr_in_range;
    logic wr_x0;
    logic wr_ok;
    logic oor_a;
    logic oor_b;

    generate
        if (HAS_OOR) begin : g_wr_range
            assign wr_in_range = {1'b0, bus.wr_addr} < (ADDR_W+1)'(NUM_REGS);
        end else begin : g_wr_full
            assign wr_in_range = 1'b1;
        end
    endgenerate

    assign wr_x0 = ZR && (bus.wr_addr == '0);
    assign wr_ok = bus.wr_en && !busy_q && wr_in_range && !wr_x0;

    regfile_read_port #(
        .XLEN     (XLEN),
        .NUM_REGS (NUM_REGS),
        .ZERO_REG (ZERO_REG)
    ) u_rd_a (
        .regs_i     (mem_q),
        .addr_i     (bus.rd_addr_a),
`ifdef REGFILE_BYPASS_EN
        .byp_en_i   (wr_ok),
        .byp_addr_i (bus.wr_addr),
        .byp_data_i (bus.wr_data),
`endif
        .data_o     (bus.rd_data_a),
        .oor_o      (oor_a)
    );

    regfile_read_port #(
        .XLEN     (XLEN),
        .NUM_REGS (NUM_REGS),
        .ZERO_REG (ZERO_REG)
    ) u_rd_b (
        .regs_i     (mem_q),
        .addr_i     (bus.rd_addr_b),
`ifdef REGFILE_BYPASS_EN
        .byp_en_i   (wr_ok),
        .byp_addr_i (bus.wr_addr),
        .byp_data_i (bus.wr_data),
`endif
        .data_o     (bus.rd_data_b),
        .oor_o      (oor_b)
    );

    // A new event in the same cycle as err_clr survives the clear.
    always_comb begin
        err_evt               = '0;
        err_evt[ERR_X0_WR]    = bus.wr_en && wr_x0;
        err_evt[ERR_WR_BUSY]  = bus.wr_en && busy_q;
        err_evt[ERR_WR_OOR]   = bus.wr_en && !wr_in_range;
        err_evt[ERR_RD_OOR]   = oor_a || oor_b;
        err_evt[ERR_CLR_BUSY] = bus.clr_req && busy_q;
        err_d                 = (bus.err_clr ? '0 : err_q) | err_evt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q   <= '0;
            state_q <= CLR_IDLE;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            err_q   <= '0;
        end else begin
            err_q <= err_d;
            if (wr_ok) begin
                mem_q[bus.wr_addr] <= bus.wr_data;
            end
            case (state_q)
                CLR_IDLE: begin
                    if (bus.clr_req) begin
                        state_q <= CLR_RUN;
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                CLR_RUN: begin
                    mem_q[idx_q] <= '0;
                    if (idx_q == LAST_IDX) begin
                        state_q <= CLR_IDLE;
                        idx_q   <= '0;
                        busy_q  <= 1'b0;
                    end else begin
                        idx_q <= idx_q + ADDR_W'(1);
                    end
                end
                default: begin
                    state_q <= CLR_IDLE;
                    idx_q   <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.clr_busy     = busy_q;
    assign bus.error_vector = err_q;

endmodule

// File: tb/tb_regfile_v2.sv
// Scoreboard bench for regfile_v2: a 32-entry and a 24-entry instance share stimulus,
// each checked against an array-based reference model.
module tb_regfile_v2;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    regfile_v2_if #(.XLEN(32), .NUM_REGS(32)) bus32 ();
    regfile_v2_if #(.XLEN(32), .NUM_REGS(24)) bus24 ();

    regfile_v2 #(.XLEN(32), .NUM_REGS(32), .ZERO_REG(1)) dut32 (
        .clk (clk),
        .rst (rst),
        .bus (bus32.slave)
    );

    regfile_v2 #(.XLEN(32), .NUM_REGS(24), .ZERO_REG(1)) dut24 (
        .clk (clk),
        .rst (rst),
        .bus (bus24.slave)
    );

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    // Reference model state, index 0 = 32-entry DUT, index 1 = 24-entry DUT.
    logic [31:0]  m_mem  [2][32];
    bit           m_busy [2];
    int unsigned  m_pos  [2];
    logic [7:0]   m_err  [2];

    logic        s_we, s_cr, s_ec;
    logic [4:0]  s_wa, s_ra, s_rb;
    logic [31:0] s_wd;

    typedef struct {
        int unsigned d;
        logic [31:0] ra;
        logic [31:0] rb;
        logic        busy;
        logic [7:0]  err;
    } exp_t;

    exp_t exp_q [$];

    int unsigned n_cmp  = 0;
    int unsigned n_fail = 0;

    function automatic int unsigned nregs(input int unsigned d);
        return (d == 0) ? 32 : 24;
    endfunction

    function automatic void check(input string nm, input int unsigned d,
                                  input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (NUM_REGS=%0d) at %0t: got %h, expected %h",
                     nm, nregs(d), $time, act, exp);
        end
    endfunction

    function automatic void model_reset(input int unsigned d);
        for (int i = 0; i < 32; i++) m_mem[d][i] = '0;
        m_busy[d] = 1'b0;
        m_pos[d]  = 0;
        m_err[d]  = '0;
    endfunction

    function automatic bit write_taken(input int unsigned d);
        return s_we && !m_busy[d] && (s_wa < nregs(d)) && (s_wa != 0);
    endfunction

    function automatic logic [31:0] model_rd(input int unsigned d, input logic [4:0] a);
        if (a >= nregs(d) || a == 0) return '0;
        if (BYP && write_taken(d) && a == s_wa) return s_wd;
        return m_mem[d][a];
    endfunction

    function automatic void model_step(input int unsigned d);
        logic [7:0] evt;
        bit         take;
        if (rst) begin
            model_reset(d);
            return;
        end
        take   = write_taken(d);
        evt    = '0;
        evt[0] = s_we && (s_wa == 0);
        evt[1] = s_we && m_busy[d];
        evt[2] = s_we && (s_wa >= nregs(d));
        evt[3] = (s_ra >= nregs(d)) || (s_rb >= nregs(d));
        evt[4] = s_cr && m_busy[d];
        m_err[d] = (s_ec ? 8'h00 : m_err[d]) | evt;
        if (take) m_mem[d][s_wa] = s_wd;
        if (m_busy[d]) begin
            m_mem[d][m_pos[d]] = '0;
            m_pos[d]++;
            if (m_pos[d] == nregs(d)) begin
                m_busy[d] = 1'b0;
                m_pos[d]  = 0;
            end
        end else if (s_cr) begin
            m_busy[d] = 1'b1;
            m_pos[d]  = 0;
        end
    endfunction

    task automatic cycle(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                         input logic [4:0] ra, input logic [4:0] rb,
                         input logic cr, input logic ec);
        @(negedge clk);
        s_we = we; s_wa = wa; s_wd = wd; s_ra = ra; s_rb = rb; s_cr = cr; s_ec = ec;
        bus32.wr_en = we; bus32.wr_addr = wa; bus32.wr_data = wd;
        bus32.rd_addr_a = ra; bus32.rd_addr_b = rb; bus32.clr_req = cr; bus32.err_clr = ec;
        bus24.wr_en = we; bus24.wr_addr = wa; bus24.wr_data = wd;
        bus24.rd_addr_a = ra; bus24.rd_addr_b = rb; bus24.clr_req = cr; bus24.err_clr = ec;
        #1;
        for (int unsigned d = 0; d < 2; d++) begin
            exp_t e;
            e.d    = d;
            e.ra   = model_rd(d, ra);
            e.rb   = model_rd(d, rb);
            e.busy = m_busy[d];
            e.err  = m_err[d];
            exp_q.push_back(e);
        end
        @(posedge clk);
        for (int unsigned d = 0; d < 2; d++) model_step(d);
    endtask

    task automatic idle(input logic [4:0] ra, input logic [4:0] rb);
        cycle(1'b0, 5'd0, 32'h0, ra, rb, 1'b0, 1'b0);
    endtask

    // Monitor: compares whatever expectations the driver queued this cycle.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            while (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                if (e.d == 0) begin
                    check("rd_data_a", 0, bus32.rd_data_a, e.ra);
                    check("rd_data_b", 0, bus32.rd_data_b, e.rb);
                    check("clr_busy", 0, {31'b0, bus32.clr_busy}, {31'b0, e.busy});
                    check("error_vector", 0, {24'b0, bus32.error_vector}, {24'b0, e.err});
                end else begin
                    check("rd_data_a", 1, bus24.rd_data_a, e.ra);
                    check("rd_data_b", 1, bus24.rd_data_b, e.rb);
                    check("clr_busy", 1, {31'b0, bus24.clr_busy}, {31'b0, e.busy});
                    check("error_vector", 1, {24'b0, bus24.error_vector}, {24'b0, e.err});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned cnt32, cnt24;
        model_reset(0);
        model_reset(1);
        s_we = 0; s_cr = 0; s_ec = 0; s_wa = 0; s_ra = 0; s_rb = 0; s_wd = 0;
        #1 rst = 1'b1;
        idle(5'd0, 5'd5);
        idle(5'd31, 5'd5);
        #1 rst = 1'b0;

        // Write then read-same-cycle and next cycle.
        cycle(1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd0, 1'b0, 1'b0);
        idle(5'd5, 5'd5);

        // x0 write is refused and flagged, then err_clr wipes the flag.
        cycle(1'b1, 5'd0, 32'h12345678, 5'd0, 5'd0, 1'b0, 1'b0);
        idle(5'd0, 5'd5);
        cycle(1'b0, 5'd0, 32'h0, 5'd0, 5'd5, 1'b0, 1'b1);
        idle(5'd0, 5'd5);

        for (int i = 1; i < 32; i++) cycle(1'b1, 5'(i), 32'(i), 5'(i), 5'(i - 1), 1'b0, 1'b0);

        // Clear sequence: count busy cycles, with a dropped write and a repeated request.
        cnt32 = 0;
        cnt24 = 0;
        cycle(1'b0, 5'd0, 32'h0, 5'd7, 5'd3, 1'b1, 1'b0);
        #1;
        cnt32 += bus32.clr_busy;
        cnt24 += bus24.clr_busy;
        for (int i = 0; i < 39; i++) begin
            cycle(i == 5, 5'd7, 32'hA5A5A5A5, 5'd7, 5'(i % 24), i == 10, 1'b0);
            #1;
            cnt32 += bus32.clr_busy;
            cnt24 += bus24.clr_busy;
        end
        check("clear_length", 0, cnt32, 32);
        check("clear_length", 1, cnt24, 24);
        for (int i = 0; i < 16; i++) idle(5'(2 * i), 5'(2 * i + 1));

        // Out-of-range write and read on the 24-entry instance.
        cycle(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b0, 1'b1);
        cycle(1'b1, 5'd9, 32'h0BADF00D, 5'd9, 5'd20, 1'b0, 1'b0);
        cycle(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b0, 1'b1);
        cycle(1'b1, 5'd30, 32'hCAFEF00D, 5'd9, 5'd28, 1'b0, 1'b0);
        idle(5'd9, 5'd23);
        idle(5'd30, 5'd30);

        // Asynchronous reset part way through a clear.
        for (int i = 1; i < 24; i++) cycle(1'b1, 5'(i), 32'(i * 3 + 1), 5'(i), 5'd0, 1'b0, 1'b0);
        cycle(1'b0, 5'd0, 32'h0, 5'd12, 5'd2, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) idle(5'(i), 5'(i + 10));
        #1 rst = 1'b1;
        for (int unsigned d = 0; d < 2; d++) model_reset(d);
        idle(5'd15, 5'd20);
        idle(5'd11, 5'd23);
        idle(5'd12, 5'd1);
        #1 rst = 1'b0;
        idle(5'd15, 5'd20);

        for (int i = 0; i < 1500; i++) begin
            cycle($urandom_range(0, 1), 5'($urandom_range(0, 31)), $urandom,
                  5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                  $urandom_range(0, 49) == 0, $urandom_range(0, 7) == 0);
        end
        idle(5'd1, 5'd2);

        @(negedge clk);
        #3;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d left, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_v2.md
Name: regfile_v2

Overview:
- Parametrised multi-port integer register file for the riscv_core. Supersedes the single 32-bit storage register.
- Provides one synchronous write port and two combinational read ports, with optional hardwired-zero x0.
- Includes a sequenced clear engine that zeroes one entry per cycle on request.
- Drives a sticky 8-bit error vector that reports illegal accesses to the core's debug/status logic.

Parameters:
- XLEN, 32, data width of each register in bits.
- NUM_REGS, 32, number of entries; any value >= 2. Need not be a power of two.
- ADDR_W, $clog2(NUM_REGS), address width of all address ports. Derived; never overridden.
- ZERO_REG, 1, when 1, entry 0 always reads 0 and is never written.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-high reset
- wr_en  in  1  write request
- wr_addr  in  ADDR_W  write address
- wr_data  in  XLEN  write data
- rd_addr_a  in  ADDR_W  read port A address
- rd_data_a  out  XLEN  read port A data
- rd_addr_b  in  ADDR_W  read port B address
- rd_data_b  out  XLEN  read port B data
- clr_req  in  1  single-cycle pulse; start sequenced clear
- clr_busy  out  1  clear sequence in progress
- err_clr  in  1  clear sticky error bits
- error_vector  out  8  sticky error flags

Behaviour:
- Reset (async assert, no clk needed):
  - all entries 0
  - FSM in IDLE, clear index 0
  - clr_busy 0, error_vector 0
  - rd_data_* follow storage combinationally, so they read 0.
- Reads:
  - combinational, zero latency: rd_data_x = storage[rd_addr_x].
  - ZERO_REG=1 and addr 0 -> 0.
  - addr >= NUM_REGS -> 0, and error bit 3 sets at the next edge.
- Write accepted at posedge when all of the following hold:
  - wr_en=1
  - clr_busy=0
  - wr_addr < NUM_REGS
  - not (ZERO_REG=1 and wr_addr=0)
  - Accepted data is visible on reads from the following cycle.
- Clear FSM states:
  - IDLE: clr_req=1 -> CLEAR, idx<=0, clr_busy<=1 (registered; high the cycle after the request).
  - CLEAR: each cycle storage[idx]<=0 and idx<=idx+1. When idx=NUM_REGS-1, that entry is zeroed, then -> IDLE with clr_busy<=0 and idx<=0.
  - Total: clr_busy high exactly NUM_REGS cycles.
- Writes on the clr_req cycle in IDLE are still accepted (clr_busy is still 0). The clear later zeroes that entry.
- During CLEAR:
  - reads return current storage (entries at or above idx keep their old value).
  - writes are dropped and set error bit 1.
  - clr_req is ignored and sets error bit 4.
- Reset mid-CLEAR: all entries 0 and the FSM returns to IDLE immediately.
- error_vector bits (sticky, set on the edge after the event):
  - [0] write to x0 attempted (ZERO_REG=1)
  - [1] write dropped while clr_busy
  - [2] wr_addr >= NUM_REGS with wr_en
  - [3] rd_addr_a or rd_addr_b >= NUM_REGS
  - [4] clr_req while clr_busy
  - [7:5] always 0
- err_clr=1 zeroes all bits at the next edge. Any error event in the same cycle wins, so that bit is set.
- Out-of-range checks apply only when NUM_REGS < 2**ADDR_W. Otherwise bits 2 and 3 stay 0.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: write-to-read forwarding. If a write is accepted this cycle and rd_addr_x == wr_addr, then rd_data_x = wr_data combinationally in the same cycle. The x0 and out-of-range rules still take priority and return 0.
- Undefined: rd_data_x returns the old stored value until the edge after the write.

Decomposition:
- Package regfile_pkg:
  - typedef enum of clear states {CLR_IDLE, CLR_RUN}
  - localparams for error bit indices: ERR_X0_WR=0, ERR_WR_BUSY=1, ERR_WR_OOR=2, ERR_RD_OOR=3, ERR_CLR_BUSY=4
  - ERR_W=8
- Sub-module regfile_read_port: one read mux, including the out-of-range/zero/bypass logic. Instantiated twice.

Test Plan:
- Reset, then write 0xDEADBEEF to x5; read A=x5 same cycle -> old value 0 (bypass off) or 0xDEADBEEF (REGFILE_BYPASS_EN); next cycle -> 0xDEADBEEF.
- Write 0x12345678 to x0 with ZERO_REG=1 -> rd x0 = 0 and error_vector=0x01. Pulse err_clr -> 0x00.
- Fill x1..x31 with their index, then pulse clr_req -> clr_busy high exactly 32 cycles; all entries read 0 afterwards. A write to x7 during CLEAR is dropped and error_vector[1]=1.
- NUM_REGS=24: write to addr 30 and read B addr 28 -> rd_data_b=0 and error_vector=0x0C. Storage is unchanged.
- Assert rst asynchronously mid-clear at idx=10 -> clr_busy=0, error_vector=0 and all entries 0 immediately, without waiting for a clock edge.
- Pulse clr_req again while clr_busy -> error_vector[4]=1, and clear length is unchanged (still NUM_REGS cycles total).
